// File: rtl/bcd_score_counter.sv
// bcd_score_counter: packed-BCD score accumulator with a one-digit-per-clock
// carry ripple and a ready/enable handshake toward the score producer.
// Build option: define BCD_SCORE_SATURATE_EN to saturate at all-9s on MSD
// carry-out; otherwise the score wraps modulo 10^COUNTER_DIGITS.
module bcd_score_counter #(
    parameter int COUNTER_DIGITS   = 6,
    parameter int COUNTER_BITWIDTH = 4 * COUNTER_DIGITS
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        enable,
    input  logic                        clear,
    input  logic [3:0]                  incValue,
    output logic                        ready,
    output logic                        overflow,
    output logic [COUNTER_BITWIDTH-1:0] countValue
);

    localparam int IDX_W = (COUNTER_DIGITS > 1) ? $clog2(COUNTER_DIGITS) : 1;

    typedef enum logic {IDLE, ADD} state_t;

    state_t                      state_q, state_d;
    logic [IDX_W-1:0]            idx_q, idx_d;
    logic [3:0]                  addend_q, addend_d;
    logic [COUNTER_BITWIDTH-1:0] count_q, count_d;
    logic                        ovf_q, ovf_d;

    logic [3:0] cur_digit;
    logic [3:0] add_in;
    logic [4:0] sum;
    logic       carry;
    logic [3:0] new_digit;

    // Single-digit BCD adder on the digit selected by the ripple index
    always_comb begin
        cur_digit = '0;
        for (int i = 0; i < COUNTER_DIGITS; i++) begin
            if (idx_q == IDX_W'(i)) cur_digit = count_q[4*i +: 4];
        end
        // Digits above the LSD are only visited when a carry is pending
        add_in    = (idx_q == '0) ? addend_q : 4'd1;
        sum       = {1'b0, cur_digit} + {1'b0, add_in};
        carry     = (sum > 5'd9);
        new_digit = carry ? 4'(sum - 5'd10) : sum[3:0];
    end

    // Next-state: accept events in IDLE, ripple one digit per cycle in ADD
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        addend_d = addend_q;
        count_d  = count_q;
        ovf_d    = 1'b0;
        if (clear) begin
            state_d = IDLE;
            idx_d   = '0;
            count_d = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (enable) begin
                        addend_d = (incValue > 4'd9) ? 4'd9 : incValue;
                        idx_d    = '0;
                        state_d  = ADD;
                    end
                end
                ADD: begin
                    for (int i = 0; i < COUNTER_DIGITS; i++) begin
                        if (idx_q == IDX_W'(i)) count_d[4*i +: 4] = new_digit;
                    end
                    if (!carry) begin
                        state_d = IDLE;
                    end else if (idx_q == IDX_W'(COUNTER_DIGITS - 1)) begin
                        ovf_d   = 1'b1;
                        state_d = IDLE;
`ifdef BCD_SCORE_SATURATE_EN
                        count_d = {COUNTER_DIGITS{4'd9}};
`else
                        // Wrapped digit already written above
`endif
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // State registers with asynchronous active-low reset
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            addend_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            addend_q <= addend_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
        end
    end

    assign ready      = (state_q == IDLE);
    assign overflow   = ovf_q;
    assign countValue = count_q;

endmodule

// File: tb/tb_bcd_score_counter.sv
// Scoreboard bench for bcd_score_counter (4-digit instance so the overflow
// boundary is reachable quickly). Stimulus pushes the expected final score,
// overflow flag and busy length; a monitor pops on each busy->ready edge.
module tb_bcd_score_counter;

    localparam int D    = 4;
    localparam int W    = 4 * D;
    localparam int MAXV = 10 ** D;
`ifdef BCD_SCORE_SATURATE_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic         clk    = 1'b0;
    logic         rst_n  = 1'b1;
    logic         enable = 1'b0;
    logic         clear  = 1'b0;
    logic [3:0]   inc    = 4'd0;
    logic         ready;
    logic         overflow;
    logic [W-1:0] count;

    always #5 clk = ~clk;

    bcd_score_counter #(.COUNTER_DIGITS(D)) dut (
        .clock     (clk),
        .reset     (rst_n),
        .enable    (enable),
        .clear     (clear),
        .incValue  (inc),
        .ready     (ready),
        .overflow  (overflow),
        .countValue(count)
    );

    typedef struct {
        int value;
        bit ovf;
        int k;      // expected busy cycles, -1 = don't check
    } exp_t;

    exp_t q[$];
    int   errors = 0;
    int   checks = 0;
    int   model  = 0;
    int   exp_ovf_total = 0;
    int   ovf_seen = 0;

    function automatic logic [W-1:0] to_bcd(input int v);
        logic [W-1:0] r;
        int t;
        r = '0;
        t = v;
        for (int i = 0; i < D; i++) begin
            r[4*i +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic wait_ready();
        int n;
        n = 0;
        while (ready !== 1'b1 && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (ready !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL ready_timeout: ready=%b expected 1", ready);
        end
    endtask

    // abort_k: 0 = normal event, >0 = will be cleared after abort_k busy
    // cycles, -1 = will be killed by async reset
    task automatic do_add(input int v, input int abort_k);
        int a, k, t, i, nv;
        bit c;
        wait_ready();
        enable = 1'b1;
        inc    = 4'(v);
        @(posedge clk); #1;
        enable = 1'b0;
        a  = (v > 9) ? 9 : v;
        c  = ((model % 10) + a) > 9;
        k  = 1;
        t  = model / 10;
        i  = 1;
        while (c && i < D) begin
            k++;
            c = ((t % 10) == 9);
            t = t / 10;
            i++;
        end
        nv = model + a;
        if (nv >= MAXV) nv = SAT ? (MAXV - 1) : (nv - MAXV);
        if (abort_k == 0) begin
            q.push_back('{value: nv, ovf: c, k: k});
            model = nv;
            if (c) exp_ovf_total++;
        end else begin
            q.push_back('{value: 0, ovf: 1'b0, k: abort_k});
            model = 0;
        end
    endtask

    task automatic reach(input int target);
        while (model < target) do_add(((target - model) > 9) ? 9 : (target - model), 0);
    endtask

    task automatic do_clear();
        wait_ready();
        clear = 1'b1;
        @(posedge clk); #1;
        clear = 1'b0;
        model = 0;
        check("clear_value", count, 0);
    endtask

    // Monitor: count busy cycles, compare on each busy->ready transition
    int   busy = 0;
    bit   was_busy = 1'b0;
    exp_t e;
    always @(negedge clk) begin
        if (overflow === 1'b1) ovf_seen++;
        if (ready === 1'b0) begin
            busy++;
            was_busy = 1'b1;
        end else if (was_busy) begin
            was_busy = 1'b0;
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_completion: score=%h expected no event", count);
            end else begin
                e = q.pop_front();
                check("score", count, to_bcd(e.value));
                check("overflow", overflow, e.ovf);
                if (e.k >= 0) check("busy_cycles", busy, e.k);
            end
            busy = 0;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset held for 3 cycles
        #1 rst_n = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
            check("rst_count", count, 0);
            check("rst_ready", ready, 1);
            check("rst_ovf", overflow, 0);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("post_rst_count", count, 0);
        check("post_rst_ready", ready, 1);

        do_add(3, 0);           // 0003, 1 cycle
        do_add(15, 0);          // clamped to 9 -> 0012
        do_add(0, 0);           // no change, 1 cycle

        reach(997);
        do_add(5, 0);           // 1002, 4 digits touched

        // Clear beats a simultaneous enable
        wait_ready();
        clear  = 1'b1;
        enable = 1'b1;
        inc    = 4'd5;
        @(posedge clk); #1;
        clear  = 1'b0;
        enable = 1'b0;
        model  = 0;
        check("clr_vs_en_count", count, 0);
        check("clr_vs_en_ready", ready, 1);

        // Enable while busy is ignored
        reach(99);
        do_add(1, 0);           // 0100
        enable = 1'b1;
        inc    = 4'd7;
        @(posedge clk); #1;
        enable = 1'b0;

        // MSD carry-out
        reach(9998);
        do_add(5, 0);           // wrap 0003 / saturate 9999
        do_add(9, 0);           // wrap 0012 / saturate 9999 again

        // Clear during the third ADD cycle
        do_clear();
        reach(999);
        do_add(1, 3);
        @(posedge clk); #1;
        @(posedge clk); #1;
        clear = 1'b1;
        @(posedge clk); #1;
        clear = 1'b0;
        check("abort_clear_count", count, 0);
        check("abort_clear_ready", ready, 1);

        // Async reset mid-ripple
        reach(999);
        do_add(1, -1);
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_count", count, 0);
        check("async_rst_ready", ready, 1);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        do_add(7, 0);           // 0007 after reset
        wait_ready();
        repeat (3) @(posedge clk);
        #1;
        check("queue_drained", q.size(), 0);
        check("overflow_pulses", ovf_seen, exp_ovf_total);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
